// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: memory-port encodings shared by the arbiter, the
// memory model and the core top (write-enable levels, size codes, owner tags).
`ifndef MM_ENB_W
`define MM_ENB_W 1'b1
`endif
`ifndef MM_ENB_R
`define MM_ENB_R 1'b0
`endif

package mem_port_arbiter_pkg;

  localparam logic [1:0] MM_SIZE_B = 2'd0;
  localparam logic [1:0] MM_SIZE_H = 2'd1;
  localparam logic [1:0] MM_SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ARB_NONE = 2'd0,
    ARB_I    = 2'd1,
    ARB_D    = 2'd2
  } resp_sel_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-port signals of the arbiter.
// slave = arbiter view, master = core/memory view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          m_EnWR;
  logic [1:0]    m_Size;
  logic [AW-1:0] m_ABus;
  logic [DW-1:0] m_DBusW;
  logic [DW-1:0] m_DBusR;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_DBusR,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_EnWR, m_Size, m_ABus, m_DBusW
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, m_DBusR,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_EnWR, m_Size, m_ABus, m_DBusW
  );
endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// arb_starve_ctr: counts consecutive cycles a fetch request was denied,
// saturating at MAX; at_max tells the arbiter to force the fetch grant.
module arb_starve_ctr #(
  parameter int unsigned MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] cnt,
  output logic       at_max
);

  assign at_max = (cnt == 4'(MAX));

  // Saturating denial counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between instruction
// fetch (I) and data load/store (D). D has priority unless I has been denied
// STARVE_MAX cycles in a row. Optional MEM_PORT_ARBITER_STATS_EN adds grant
// and conflict counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int          AW         = 32,
  parameter int          DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  mem_port_arbiter_if.slave        bus
`ifdef MEM_PORT_ARBITER_STATS_EN
  ,
  output logic [31:0]              stat_i_grants,
  output logic [31:0]              stat_d_grants,
  output logic [31:0]              stat_conflicts
`endif
);

  localparam logic [AW-1:0] ADDR_IDLE = '0;
  localparam logic [DW-1:0] DATA_IDLE = '0;

  resp_sel_e     resp_sel;
  resp_sel_e     resp_nxt;
  logic          i_gnt_c;
  logic          d_gnt_c;
  logic [3:0]    starve_cnt;
  logic          starve_at_max;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;

  arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (bus.i_req && !i_gnt_c),
    .clr    (i_gnt_c || !bus.i_req),
    .cnt    (starve_cnt),
    .at_max (starve_at_max)
  );

  // Issue stage: pick at most one owner and drive the memory port this cycle.
  always_comb begin
    i_gnt_c      = 1'b0;
    d_gnt_c      = 1'b0;
    resp_nxt     = ARB_NONE;
    bus.m_EnWR   = `MM_ENB_R;
    bus.m_Size   = MM_SIZE_W;
    bus.m_ABus   = ADDR_IDLE;
    bus.m_DBusW  = DATA_IDLE;
    if (!rst) begin
      if (bus.d_req && !(bus.i_req && starve_at_max)) begin
        d_gnt_c     = 1'b1;
        resp_nxt    = ARB_D;
        bus.m_EnWR  = bus.d_we ? `MM_ENB_W : `MM_ENB_R;
        bus.m_Size  = bus.d_size;
        bus.m_ABus  = bus.d_addr;
        bus.m_DBusW = bus.d_wdata;
      end else if (bus.i_req) begin
        i_gnt_c     = 1'b1;
        resp_nxt    = ARB_I;
        bus.m_ABus  = bus.i_addr;
      end
    end
    bus.i_gnt = i_gnt_c;
    bus.d_gnt = d_gnt_c;
  end

  // Response owner register: who receives m_DBusR next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_sel <= ARB_NONE;
    end else begin
      resp_sel <= resp_nxt;
    end
  end

  // Response routing; rst masks rvalid so an in-flight response is dropped.
  always_comb begin
    bus.i_rvalid = (resp_sel == ARB_I) && !rst;
    bus.d_rvalid = (resp_sel == ARB_D) && !rst;
    bus.i_rdata  = bus.i_rvalid ? bus.m_DBusR : i_rdata_q;
    bus.d_rdata  = bus.d_rvalid ? bus.m_DBusR : d_rdata_q;
  end

  // Hold registers keep each rdata at its last delivered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_rdata_q <= bus.i_rdata;
      d_rdata_q <= bus.d_rdata;
    end
  end

`ifdef MEM_PORT_ARBITER_STATS_EN
  // Event counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_i_grants  <= '0;
      stat_d_grants  <= '0;
      stat_conflicts <= '0;
    end else begin
      if (i_gnt_c) stat_i_grants <= stat_i_grants + 32'd1;
      if (d_gnt_c) stat_d_grants <= stat_d_grants + 32'd1;
      if (bus.i_req && bus.d_req) stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif

  // A requester must hold req until it is granted.
  a_i_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.i_req && !bus.i_gnt) |=> bus.i_req);
  a_d_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.d_req && !bus.d_gnt) |=> bus.d_req);
  a_starve_bound: assert property (@(posedge clk) disable iff (rst)
    starve_cnt <= 4'(STARVE_MAX));

endmodule
